// File: rtl/stopwatch_pkg.sv
`default_nettype none
// ============================================================================
// Module  : stopwatch_pkg
// Purpose : Shared state encoding, BCD digit type and digit limits.
// Revision: 1.0 - initial release
// ============================================================================
package stopwatch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN1  = 2'd1,
    RUN10 = 2'd2,
    HOLD  = 2'd3
  } ctrl_state_t;

  typedef logic [3:0] bcd_t;

  localparam bcd_t C_MAX      = 4'd9;
  localparam bcd_t S_TENS_MAX = 4'd5;
  localparam bcd_t M_TENS_MAX = 4'd5;

  // Digit order: 0=c_ones 1=c_tens 2=s_ones 3=s_tens 4=m_ones 5=m_tens
  function automatic bcd_t digit_max(input int idx);
    if (idx == 3)      return S_TENS_MAX;
    else if (idx == 5) return M_TENS_MAX;
    else               return C_MAX;
  endfunction

endpackage
`default_nettype wire

// File: rtl/stopwatch_timebase_ctrl_bcd_digit.sv
`default_nettype none
// ============================================================================
// Module  : bcd_digit
// Purpose : One mod-(MAX+1) BCD digit with increment, clear and carry out.
// Revision: 1.0 - initial release
// ============================================================================
module bcd_digit
  import stopwatch_pkg::*;
#(
  parameter bcd_t MAX = C_MAX
) (
  input  logic clk,
  input  logic rst,
  input  logic inc_i,
  input  logic clr_i,
  output bcd_t digit_o,
  output logic carry_out_o
);

  bcd_t digit_q;
  bcd_t digit_d;

  // Out-of-range values wrap on the next increment so the digit stays BCD.
  always_comb begin
    digit_d = digit_q;
    if (clr_i)
      digit_d = '0;
    else if (inc_i)
      digit_d = (digit_q >= MAX) ? '0 : digit_q + 4'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) digit_q <= '0;
    else     digit_q <= digit_d;
  end

  assign digit_o     = digit_q;
  assign carry_out_o = inc_i && !clr_i && (digit_q >= MAX);

endmodule
`default_nettype wire

// File: rtl/stopwatch_timebase_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : stopwatch_timebase_ctrl
// Purpose : Run-mode sequencer, 1x/fast prescaler and BCD mm:ss.cc counter.
//           Optional lap-hold display enabled by defining LAP_EN.
// Revision: 1.0 - initial release
// ============================================================================
module stopwatch_timebase_ctrl
  import stopwatch_pkg::*;
#(
  parameter int TICK_DIV = 100,
  parameter int SPEEDUP  = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run_1x,
  input  logic        run_10x,
  input  logic        pause,
  input  logic        clear,
`ifdef LAP_EN
  input  logic        lap,
  output logic        lap_active,
`endif
  output logic [23:0] time_bcd,
  output logic        tick,
  output logic        rollover,
  output logic        running
);

  localparam int            PW       = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] LAST_1X  = PW'(TICK_DIV - 1);
  localparam logic [PW-1:0] LAST_10X = PW'(TICK_DIV / SPEEDUP - 1);

  ctrl_state_t   state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          fast_q;
  logic          tick_q, rollover_q, running_q;
  logic          run_d, fast_d, inc;
  logic [6:0]    carry;
  bcd_t          digit [6];
  logic [23:0]   live_time;

  always_comb begin
    state_d = state_q;
    if (clear)
      state_d = IDLE;
    else if (pause) begin
      if (state_q != IDLE) state_d = HOLD;
    end
    else if (run_10x)
      state_d = RUN10;
    else if (run_1x)
      state_d = RUN1;
  end

  assign run_d  = (state_d == RUN1) || (state_d == RUN10);
  assign fast_d = (state_d == RUN10);

  // A rate change restarts the prescale period; IDLE always holds it at zero.
  always_comb begin
    presc_d = presc_q;
    inc     = 1'b0;
    if (clear)
      presc_d = '0;
    else if (run_d) begin
      if ((state_q != IDLE) && (fast_d != fast_q))
        presc_d = '0;
      else if (presc_q == (fast_d ? LAST_10X : LAST_1X)) begin
        presc_d = '0;
        inc     = 1'b1;
      end
      else
        presc_d = presc_q + PW'(1);
    end
  end

  assign carry[0] = inc;

  for (genvar i = 0; i < 6; i++) begin : g_digit
    bcd_digit #(.MAX(digit_max(i))) u_digit (
      .clk         (clk),
      .rst         (rst),
      .inc_i       (carry[i]),
      .clr_i       (clear),
      .digit_o     (digit[i]),
      .carry_out_o (carry[i+1])
    );
  end

  assign live_time = {digit[5], digit[4], digit[3], digit[2], digit[1], digit[0]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      presc_q    <= '0;
      fast_q     <= 1'b0;
      tick_q     <= 1'b0;
      rollover_q <= 1'b0;
      running_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      presc_q    <= presc_d;
      if (run_d) fast_q <= fast_d;
      tick_q     <= inc;
      rollover_q <= carry[6];
      running_q  <= run_d;
    end
  end

  assign tick     = tick_q;
  assign rollover = rollover_q;
  assign running  = running_q;

`ifdef LAP_EN
  logic        lap_prev_q, lap_active_q;
  logic [23:0] lap_time_q;
  logic        lap_rise;

  assign lap_rise = lap && !lap_prev_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lap_prev_q   <= 1'b0;
      lap_active_q <= 1'b0;
      lap_time_q   <= '0;
    end else begin
      lap_prev_q <= lap;
      if (clear)
        lap_active_q <= 1'b0;
      else if (lap_rise && lap_active_q)
        lap_active_q <= 1'b0;
      else if (lap_rise && ((state_q == RUN1) || (state_q == RUN10))) begin
        lap_active_q <= 1'b1;
        lap_time_q   <= live_time;
      end
    end
  end

  assign lap_active = lap_active_q;
  assign time_bcd   = lap_active_q ? lap_time_q : live_time;
`else
  assign time_bcd   = live_time;
`endif

endmodule
`default_nettype wire

// File: tb/tb_stopwatch_timebase_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_stopwatch_timebase_ctrl
// Purpose : Directed self-checking bench, TICK_DIV=4 / SPEEDUP=2.
// Revision: 1.0 - initial release
// ============================================================================
module tb_stopwatch_timebase_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        run_1x = 1'b0, run_10x = 1'b0, pause = 1'b0, clear = 1'b0;
  logic [23:0] time_bcd;
  logic        tick, rollover, running;
  logic [23:0] pre_v = '0;
  int          n_cmp = 0;
  int          n_bad = 0;
`ifdef LAP_EN
  logic        lap = 1'b0;
  logic        lap_active;
`endif

  stopwatch_timebase_ctrl #(.TICK_DIV(4), .SPEEDUP(2)) dut (
    .clk      (clk),
    .rst      (rst),
    .run_1x   (run_1x),
    .run_10x  (run_10x),
    .pause    (pause),
    .clear    (clear),
`ifdef LAP_EN
    .lap      (lap),
    .lap_active (lap_active),
`endif
    .time_bcd (time_bcd),
    .tick     (tick),
    .rollover (rollover),
    .running  (running)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [23:0] obs, input logic [23:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_clear();
    clear = 1'b1; run_1x = 1'b0; run_10x = 1'b0; pause = 1'b0;
    step(1);
    clear = 1'b0;
  endtask

  // Held across one idle edge so the digit registers latch the forced value.
  task automatic preload(input logic [23:0] v);
    pre_v = v;
    force dut.g_digit[0].u_digit.digit_q = pre_v[3:0];
    force dut.g_digit[1].u_digit.digit_q = pre_v[7:4];
    force dut.g_digit[2].u_digit.digit_q = pre_v[11:8];
    force dut.g_digit[3].u_digit.digit_q = pre_v[15:12];
    force dut.g_digit[4].u_digit.digit_q = pre_v[19:16];
    force dut.g_digit[5].u_digit.digit_q = pre_v[23:20];
    step(1);
    release dut.g_digit[0].u_digit.digit_q;
    release dut.g_digit[1].u_digit.digit_q;
    release dut.g_digit[2].u_digit.digit_q;
    release dut.g_digit[3].u_digit.digit_q;
    release dut.g_digit[4].u_digit.digit_q;
    release dut.g_digit[5].u_digit.digit_q;
    #1;
  endtask

  initial begin
    step(2);
    rst = 1'b0;
    step(1);
    chk("reset_time", time_bcd, 24'h000000);
    chk("reset_flags", {21'd0, tick, rollover, running}, 24'd0);

    // 1x counting from IDLE
    run_1x = 1'b1;
    step(3);
    chk("run1_no_tick_yet", {23'd0, tick}, 24'd0);
    step(1);
    chk("run1_first_tick", {23'd0, tick}, 24'd1);
    chk("run1_running", {23'd0, running}, 24'd1);
    step(8);
    chk("run1_12cyc_time", time_bcd, 24'h000003);
    do_clear();
    chk("clear_time", time_bcd, 24'h000000);
    chk("clear_running", {23'd0, running}, 24'd0);

    // fast counting from IDLE
    run_10x = 1'b1;
    step(1);
    chk("run10_tick0", {23'd0, tick}, 24'd0);
    step(1);
    chk("run10_tick1", {23'd0, tick}, 24'd1);
    step(6);
    chk("run10_8cyc_time", time_bcd, 24'h000004);
    do_clear();

    // rate change mid-period restarts the prescaler
    run_1x = 1'b1;
    step(2);
    run_1x = 1'b0; run_10x = 1'b1;
    step(2);
    chk("ratechg_no_tick", {23'd0, tick}, 24'd0);
    step(1);
    chk("ratechg_tick", {tick, time_bcd[22:0]}, {1'b1, 23'h000001});
    do_clear();

    // hold freezes the prescaler at 2
    run_1x = 1'b1;
    step(6);
    chk("hold_pre_time", time_bcd, 24'h000001);
    run_1x = 1'b0; pause = 1'b1;
    step(1);
    chk("hold_running", {23'd0, running}, 24'd0);
    step(9);
    chk("hold_frozen", {tick, time_bcd[22:0]}, {1'b0, 23'h000001});
    pause = 1'b0; run_1x = 1'b1;
    step(1);
    chk("resume_no_tick", {23'd0, tick}, 24'd0);
    step(1);
    chk("resume_tick", {tick, time_bcd[22:0]}, {1'b1, 23'h000002});
    do_clear();

    // clear on the same edge as a prescaler wrap
    run_1x = 1'b1;
    step(7);
    chk("preclr_time", time_bcd, 24'h000001);
    clear = 1'b1;
    step(1);
    clear = 1'b0; run_1x = 1'b0;
    chk("clr_wrap_time", time_bcd, 24'h000000);
    chk("clr_wrap_flags", {21'd0, tick, rollover, running}, 24'd0);

    // minute carry
    preload(24'h005999);
    chk("preload_time", time_bcd, 24'h005999);
    run_1x = 1'b1;
    step(3);
    chk("carry_no_tick", {23'd0, tick}, 24'd0);
    step(1);
    chk("carry_min_time", time_bcd, 24'h010000);
    chk("carry_min_flags", {22'd0, tick, rollover}, 24'd2);
    step(1);
    chk("carry_tick_drop", {23'd0, tick}, 24'd0);
    do_clear();

    // full wrap
    preload(24'h595999);
    run_1x = 1'b1;
    step(4);
    chk("wrap_time", time_bcd, 24'h000000);
    chk("wrap_flags", {22'd0, tick, rollover}, 24'd3);
    step(1);
    chk("wrap_roll_drop", {23'd0, rollover}, 24'd0);
    step(5);
    chk("after_wrap_time", time_bcd, 24'h000001);

    // asynchronous reset mid-count
    #2 rst = 1'b1;
    #1;
    chk("async_rst_time", time_bcd, 24'h000000);
    chk("async_rst_flags", {21'd0, tick, rollover, running}, 24'd0);
    run_1x = 1'b0;
    step(1);
    rst = 1'b0;
    step(1);

`ifdef LAP_EN
    run_1x = 1'b1;
    step(8);
    chk("lap_pre_time", time_bcd, 24'h000002);
    lap = 1'b1;
    step(1);
    lap = 1'b0;
    step(32);
    chk("lap_hold_time", time_bcd, 24'h000002);
    chk("lap_active_on", {23'd0, lap_active}, 24'd1);
    lap = 1'b1;
    step(1);
    lap = 1'b0;
    chk("lap_release_time", time_bcd, 24'h000010);
    chk("lap_active_off", {23'd0, lap_active}, 24'd0);
    do_clear();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
